// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - PC register, IF/ID register and debug event counters driven by hazard-unit controls
module fetch_stage_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013),
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             if_flush,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  pcReg;
    logic [XLEN-1:0]  ifIdPcReg;
    logic [XLEN-1:0]  ifIdInstrReg;
    logic             ifIdValidReg;
    logic [CNT_W-1:0] stallCntReg;
    logic [CNT_W-1:0] flushCntReg;
    logic [CNT_W-1:0] fetchCntReg;

    logic             stallEvent;
    logic             fetchEvent;
    logic [XLEN-1:0]  redirectPc;
    logic [XLEN-1:0]  pcNext;

    // Decode the hazard controls; a flush overrides both write enables
    always_comb begin
        stallEvent = 1'b0;
        fetchEvent = 1'b0;
        redirectPc = {branch_target[XLEN-1:2], 2'b00};
        pcNext     = pcReg;
        if (if_flush) begin
            pcNext = redirectPc;
        end else begin
            stallEvent = !pc_write;
            fetchEvent = if_id_write;
            if (pc_write) begin
                pcNext = pcReg + XLEN'(4);
            end
        end
    end

    // PC register: redirect, advance by one word (wrapping), or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            pcReg <= pcNext;
        end
    end

    // IF/ID register: bubble on flush, latch the fetched word when enabled, else hold
    always_ff @(posedge clk) begin
        if (rst || if_flush) begin
            ifIdPcReg    <= '0;
            ifIdInstrReg <= NOP_INSTR;
            ifIdValidReg <= 1'b0;
        end else if (fetchEvent) begin
            ifIdPcReg    <= pcReg;
            ifIdInstrReg <= imem_rdata;
            ifIdValidReg <= 1'b1;
        end
    end

    // Saturating debug counters for stall, flush and fetch events
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
            fetchCntReg <= '0;
        end else begin
            if (stallEvent && stallCntReg != CNT_MAX) begin
                stallCntReg <= stallCntReg + CNT_W'(1);
            end
            if (if_flush && flushCntReg != CNT_MAX) begin
                flushCntReg <= flushCntReg + CNT_W'(1);
            end
            if (fetchEvent && fetchCntReg != CNT_MAX) begin
                fetchCntReg <= fetchCntReg + CNT_W'(1);
            end
        end
    end

    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign if_id_pc    = ifIdPcReg;
    assign if_id_instr = ifIdInstrReg;
    assign if_id_valid = ifIdValidReg;
    assign stall_cnt   = stallCntReg;
    assign flush_cnt   = flushCntReg;
    assign fetch_cnt   = fetchCntReg;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - self-checking bench for fetch_stage_ctrl (default and wrap/saturate instances)
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        pcWr;
    logic        ifIdWr;
    logic        flush;
    logic [31:0] brTarget;
    logic        memMode;

    int nCompared;
    int nMismatched;

    // Instance A: default parameters
    logic [31:0] addrA, rdataA, pcA, ifPcA, instrA;
    logic        validA;
    logic [15:0] stallA, flushA, fetchA;

    // Instance B: PC starts one word below wrap, 2-bit counters
    logic [31:0] addrB, rdataB, pcB, ifPcB, instrB;
    logic        validB;
    logic [1:0]  stallB, flushB, fetchB;

    assign rdataA = memMode ? addrA + 32'd100 : 32'hDEAD_BEEF;
    assign rdataB = memMode ? addrB + 32'd100 : 32'hDEAD_BEEF;

    fetch_stage_ctrl dutA (
        .clk(clk), .rst(rst), .pc_write(pcWr), .if_id_write(ifIdWr), .if_flush(flush),
        .branch_target(brTarget), .imem_addr(addrA), .imem_rdata(rdataA), .pc(pcA),
        .if_id_pc(ifPcA), .if_id_instr(instrA), .if_id_valid(validA),
        .stall_cnt(stallA), .flush_cnt(flushA), .fetch_cnt(fetchA)
    );

    fetch_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .pc_write(pcWr), .if_id_write(ifIdWr), .if_flush(flush),
        .branch_target(brTarget), .imem_addr(addrB), .imem_rdata(rdataB), .pc(pcB),
        .if_id_pc(ifPcB), .if_id_instr(instrB), .if_id_valid(validB),
        .stall_cnt(stallB), .flush_cnt(flushB), .fetch_cnt(fetchB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state of each instance, advanced once per rising edge
    logic [31:0] mPc[2], mIfPc[2], mInstr[2];
    logic        mValid[2];
    int          mStall[2], mFlush[2], mFetch[2];
    logic [31:0] resetPc[2] = '{32'h0, 32'hFFFF_FFFC};
    int          cntMax[2]  = '{65535, 3};
    logic        modelOk    = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] word;
            word = memMode ? mPc[i] + 32'd100 : 32'hDEAD_BEEF;
            if (rst) begin
                mPc[i] = resetPc[i];
                mIfPc[i] = 32'h0;
                mInstr[i] = 32'h13;
                mValid[i] = 1'b0;
                mStall[i] = 0;
                mFlush[i] = 0;
                mFetch[i] = 0;
            end else if (flush) begin
                mPc[i] = brTarget & ~32'h3;
                mIfPc[i] = 32'h0;
                mInstr[i] = 32'h13;
                mValid[i] = 1'b0;
                if (mFlush[i] < cntMax[i]) mFlush[i]++;
            end else begin
                if (ifIdWr) begin
                    mIfPc[i] = mPc[i];
                    mInstr[i] = word;
                    mValid[i] = 1'b1;
                    if (mFetch[i] < cntMax[i]) mFetch[i]++;
                end
                if (pcWr) mPc[i] = mPc[i] + 32'd4;
                else if (mStall[i] < cntMax[i]) mStall[i]++;
            end
        end
        if (rst) modelOk = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpInst(input int i, input string tag, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] ip, input logic [31:0] ins, input logic v,
                           input logic [31:0] st, input logic [31:0] fl, input logic [31:0] fe);
        check({tag, " pc"}, p, mPc[i]);
        check({tag, " imem_addr"}, a, mPc[i]);
        check({tag, " if_id_pc"}, ip, mIfPc[i]);
        check({tag, " if_id_instr"}, ins, mInstr[i]);
        check({tag, " if_id_valid"}, {31'b0, v}, {31'b0, mValid[i]});
        check({tag, " stall_cnt"}, st, mStall[i]);
        check({tag, " flush_cnt"}, fl, mFlush[i]);
        check({tag, " fetch_cnt"}, fe, mFetch[i]);
    endtask

    // Every cycle after the first reset, both instances must match the model
    always @(posedge clk) begin
        #1;
        if (modelOk) begin
            cmpInst(0, "A", pcA, addrA, ifPcA, instrA, validA, 32'(stallA), 32'(flushA), 32'(fetchA));
            cmpInst(1, "B", pcB, addrB, ifPcB, instrB, validB, 32'(stallB), 32'(flushB), 32'(fetchB));
        end
    end

    task automatic step(input logic r, input logic fl, input logic pw, input logic iw, input logic [31:0] bt);
        rst = r;
        flush = fl;
        pcWr = pw;
        ifIdWr = iw;
        brTarget = bt;
        @(negedge clk);
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst = 1'b1; flush = 1'b0; pcWr = 1'b0; ifIdWr = 1'b0; brTarget = 32'h0; memMode = 1'b0;
        @(negedge clk);

        // Reset for two cycles with garbage on the instruction bus
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst A pc", pcA, 32'h0);
        check("rst A instr", instrA, 32'h13);
        check("rst A valid", {31'b0, validA}, 32'h0);
        check("rst A fetch_cnt", 32'(fetchA), 32'h0);
        check("rst B pc", pcB, 32'hFFFF_FFFC);

        // Sequential fetch
        memMode = 1'b1;
        repeat (4) step(0, 0, 1, 1, 0);
        check("seq A pc", pcA, 32'h10);
        check("seq A if_id_pc", ifPcA, 32'hC);
        check("seq A instr", instrA, 32'h70);
        check("seq A fetch_cnt", 32'(fetchA), 32'd4);
        step(0, 0, 1, 1, 0);
        check("wrap B pc", pcB, 32'h10);
        check("wrap B if_id_pc", ifPcB, 32'hC);
        check("sat B fetch_cnt", 32'(fetchB), 32'd3);

        // Reset mid-run while a flush is requested
        step(1, 1, 0, 0, 32'h80);
        check("midrst A pc", pcA, 32'h0);
        check("midrst B pc", pcB, 32'hFFFF_FFFC);
        check("midrst B fetch_cnt", 32'(fetchB), 32'd0);
        check("midrst A flush_cnt", 32'(flushA), 32'd0);
        check("midrst A valid", {31'b0, validA}, 32'h0);

        // Load-use stall at pc=0x8
        repeat (2) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        check("stall A pc", pcA, 32'h8);
        check("stall A if_id_pc", ifPcA, 32'h4);
        check("stall A instr", instrA, 32'h68);
        check("stall A stall_cnt", 32'(stallA), 32'd1);
        step(0, 0, 1, 1, 0);
        check("resume A if_id_pc", ifPcA, 32'h8);
        check("resume A instr", instrA, 32'h6C);
        check("resume A pc", pcA, 32'hC);

        // Taken branch to 0x40
        step(0, 1, 1, 1, 32'h40);
        check("flush A pc", pcA, 32'h40);
        check("flush A valid", {31'b0, validA}, 32'h0);
        check("flush A instr", instrA, 32'h13);
        check("flush A if_id_pc", ifPcA, 32'h0);
        check("flush A flush_cnt", 32'(flushA), 32'd1);
        step(0, 0, 1, 1, 0);
        check("target A if_id_pc", ifPcA, 32'h40);
        check("target A instr", instrA, 32'hA4);
        check("target A pc", pcA, 32'h44);

        // Flush together with a stall, misaligned target
        step(0, 1, 0, 0, 32'h23);
        check("flstall A pc", pcA, 32'h20);
        check("flstall A valid", {31'b0, validA}, 32'h0);
        check("flstall A stall_cnt", 32'(stallA), 32'd1);
        check("flstall A flush_cnt", 32'(flushA), 32'd2);

        // Mismatched enables
        step(0, 0, 1, 0, 0);
        check("pwonly A pc", pcA, 32'h24);
        check("pwonly A valid", {31'b0, validA}, 32'h0);
        step(0, 0, 0, 1, 0);
        check("iwonly A pc", pcA, 32'h24);
        check("iwonly A if_id_pc", ifPcA, 32'h24);
        check("iwonly A instr", instrA, 32'h88);
        check("iwonly A stall_cnt", 32'(stallA), 32'd2);

        // Push the 2-bit counters into saturation
        repeat (3) step(0, 0, 0, 0, 0);
        check("stall A stall_cnt", 32'(stallA), 32'd5);
        check("sat B stall_cnt", 32'(stallB), 32'd3);
        repeat (2) step(0, 1, 1, 1, 32'h100);
        check("fl A flush_cnt", 32'(flushA), 32'd4);
        check("sat B flush_cnt", 32'(flushB), 32'd3);
        check("fl B pc", pcB, 32'h100);
        step(0, 0, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
